// File: rtl/btn_pkg.sv
// Shared definitions for the push-button BCD entry block.
// Contents: button index constants, repeat FSM state encoding, BCD digit
// width and modulus.
package btn_pkg;

    localparam int BTN_UP   = 0;
    localparam int BTN_DN   = 1;
    localparam int BTN_MODE = 2;
    localparam int BTN_N    = 3;

    localparam int BCD_W    = 4;
    localparam int BCD_MOD  = 100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

endpackage

// File: rtl/btn_bcd_entry_if.sv
// Button / BCD value bundle between the entry block and its user.
// Signals:
//   BTN       raw buttons, active-high: [0]=up, [1]=down, [2]=step-mode toggle
//   BCD_TENS  tens digit 0..9
//   BCD_ONES  ones digit 0..9
//   VALUE     binary value 0..99, always consistent with the digits
//   STEP10    0: step is 1, 1: step is 10
//   CHG       one-cycle pulse in the cycle a new value first appears
//   BTN_DB    debounced button levels
// Modports: master = entry block, slave = consumer / button source.
interface btn_bcd_entry_if;
    import btn_pkg::*;

    logic [BTN_N-1:0] BTN;
    logic [BCD_W-1:0] BCD_TENS;
    logic [BCD_W-1:0] BCD_ONES;
    logic [6:0]       VALUE;
    logic             STEP10;
    logic             CHG;
    logic [BTN_N-1:0] BTN_DB;

    modport master (
        input  BTN,
        output BCD_TENS, BCD_ONES, VALUE, STEP10, CHG, BTN_DB
    );

    modport slave (
        output BTN,
        input  BCD_TENS, BCD_ONES, VALUE, STEP10, CHG, BTN_DB
    );

endinterface

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-flop synchroniser, stability counter,
// debounced level and a registered rising-edge pulse.
// Ports:
//   INCLK     system clock
//   RST       asynchronous active-low reset
//   btn_raw   asynchronous raw button level
//   btn_db    debounced level
//   btn_rise  one-cycle pulse, high in the same cycle btn_db first reads 1
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 200000
) (
    input  logic INCLK,
    input  logic RST,
    input  logic btn_raw,
    output logic btn_db,
    output logic btn_rise
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge INCLK or negedge RST) begin
        if (!RST) begin
            sync_q   <= 2'b00;
            cnt_q    <= '0;
            btn_db   <= 1'b0;
            btn_rise <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_raw};
            btn_rise <= 1'b0;
            // Count consecutive cycles of disagreement; any agreement restarts.
            if (sync_q[1] != btn_db) begin
                if (cnt_q == CNT_LAST) begin
                    btn_db   <= sync_q[1];
                    btn_rise <= sync_q[1];
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/btn_bcd_entry.sv
// Push-button entry of a two-digit BCD value 00..99.
// Buttons are synchronised and debounced; up/down each have an auto-repeat
// FSM (IDLE -> DELAY -> REPEAT); the mode button toggles the step between
// 1 and 10. Arithmetic is done directly on the BCD digits, modulo 100.
// Ports:
//   INCLK  system clock
//   RST    asynchronous active-low reset
//   bus    btn_bcd_entry_if.master (BTN in; digits, VALUE, STEP10, CHG, BTN_DB out)
module btn_bcd_entry
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = 200000,
    parameter int REPEAT_DELAY_CYC = 5000000,
    parameter int REPEAT_RATE_CYC  = 1000000
) (
    input  logic                INCLK,
    input  logic                RST,
    btn_bcd_entry_if.master     bus
);

    localparam int RPT_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                             REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int               RPT_W      = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE_CYC - 1);

    logic [BTN_N-1:0] btn_db;
    logic [BTN_N-1:0] btn_rise;
    logic [1:0]       step;
    logic             both_held;

    logic [BCD_W-1:0] tens_q;
    logic [BCD_W-1:0] ones_q;
    logic             step10_q;
    logic             chg_q;

    function automatic logic [2*BCD_W-1:0] bcd_up(input logic [BCD_W-1:0] t,
                                                  input logic [BCD_W-1:0] o,
                                                  input logic             s10);
        logic [BCD_W-1:0] nt;
        logic [BCD_W-1:0] no;
        nt = t;
        no = o;
        if (s10 || o == 4'd9) begin
            nt = (t == 4'd9) ? 4'd0 : t + 4'd1;
            if (!s10) no = 4'd0;
        end else begin
            no = o + 4'd1;
        end
        return {nt, no};
    endfunction

    function automatic logic [2*BCD_W-1:0] bcd_dn(input logic [BCD_W-1:0] t,
                                                  input logic [BCD_W-1:0] o,
                                                  input logic             s10);
        logic [BCD_W-1:0] nt;
        logic [BCD_W-1:0] no;
        nt = t;
        no = o;
        if (s10 || o == 4'd0) begin
            nt = (t == 4'd0) ? 4'd9 : t - 4'd1;
            if (!s10) no = 4'd9;
        end else begin
            no = o - 4'd1;
        end
        return {nt, no};
    endfunction

    for (genvar i = 0; i < BTN_N; i++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_debounce (
            .INCLK    (INCLK),
            .RST      (RST),
            .btn_raw  (bus.BTN[i]),
            .btn_db   (btn_db[i]),
            .btn_rise (btn_rise[i])
        );
    end

    assign both_held = btn_db[BTN_UP] & btn_db[BTN_DN];

    // Index 0 is up, index 1 is down (matches BTN_UP / BTN_DN).
    for (genvar d = 0; d < 2; d++) begin : g_rpt
        rpt_state_t       state_q;
        rpt_state_t       state_d;
        logic [RPT_W-1:0] cnt_q;
        logic [RPT_W-1:0] cnt_d;
        logic             step_d;

        always_ff @(posedge INCLK or negedge RST) begin
            if (!RST) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            step_d  = 1'b0;
            // Release or opposing button held drops straight to IDLE; a press
            // event is then required to start again.
            if (!btn_db[d] || both_held) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (btn_rise[d]) begin
                            state_d = DELAY;
                            cnt_d   = '0;
                            step_d  = 1'b1;
                        end
                    end
                    DELAY: begin
                        if (cnt_q == DELAY_LAST) begin
                            state_d = REPEAT;
                            cnt_d   = '0;
                            step_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + RPT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (cnt_q == RATE_LAST) begin
                            cnt_d  = '0;
                            step_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + RPT_W'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        assign step[d] = step_d;
    end

    // Step and mode toggle can share a cycle; the step sees the old STEP10.
    always_ff @(posedge INCLK or negedge RST) begin
        if (!RST) begin
            tens_q   <= '0;
            ones_q   <= '0;
            step10_q <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            if (step[BTN_UP]) begin
                {tens_q, ones_q} <= bcd_up(tens_q, ones_q, step10_q);
            end else if (step[BTN_DN]) begin
                {tens_q, ones_q} <= bcd_dn(tens_q, ones_q, step10_q);
            end
            chg_q <= |step;
            if (btn_rise[BTN_MODE]) begin
                step10_q <= ~step10_q;
            end
        end
    end

    assign bus.BCD_TENS = tens_q;
    assign bus.BCD_ONES = ones_q;
    assign bus.VALUE    = 7'(tens_q) * 7'd10 + 7'(ones_q);
    assign bus.STEP10   = step10_q;
    assign bus.CHG      = chg_q;
    assign bus.BTN_DB   = btn_db;

endmodule

// File: tb/tb_btn_bcd_entry.sv
// Self-checking bench for btn_bcd_entry with short timing parameters.
module tb_btn_bcd_entry;
    import btn_pkg::*;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 5;

    logic INCLK;
    logic RST;

    btn_bcd_entry_if bus ();

    btn_bcd_entry #(
        .DEBOUNCE_CYC     (DB),
        .REPEAT_DELAY_CYC (RD),
        .REPEAT_RATE_CYC  (RR)
    ) dut (
        .INCLK (INCLK),
        .RST   (RST),
        .bus   (bus)
    );

    initial INCLK = 1'b0;
    always #5 INCLK = ~INCLK;

    int n_chk  = 0;
    int n_fail = 0;
    int chg_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: value as an integer mod 100, repeat as hold time.
    int       m_val;
    bit       m_step10;
    bit       m_chg;
    bit [2:0] m_db, m_rise, m_s1, m_s2;
    int       m_cnt [3];
    bit       m_act [2];
    int       m_hold[2];
    bit [2:0] db_o, rise_o;
    bit       both;
    bit [1:0] stp;
    int       inc;

    always @(posedge INCLK or negedge RST) begin
        if (!RST) begin
            m_val = 0; m_step10 = 0; m_chg = 0;
            m_db = 0; m_rise = 0; m_s1 = 0; m_s2 = 0;
            for (int b = 0; b < 3; b++) m_cnt[b] = 0;
            for (int d = 0; d < 2; d++) begin m_act[d] = 0; m_hold[d] = 0; end
        end else begin
            db_o   = m_db;
            rise_o = m_rise;
            both   = db_o[0] & db_o[1];
            for (int d = 0; d < 2; d++) begin
                stp[d] = 0;
                if (!db_o[d] || both) begin
                    m_act[d] = 0;
                end else if (rise_o[d]) begin
                    m_act[d] = 1; m_hold[d] = 0; stp[d] = 1;
                end else if (m_act[d]) begin
                    m_hold[d]++;
                    if (m_hold[d] == RD || (m_hold[d] > RD && (m_hold[d] - RD) % RR == 0))
                        stp[d] = 1;
                end
            end
            inc = m_step10 ? 10 : 1;
            if (stp[0])      m_val = (m_val + inc) % BCD_MOD;
            else if (stp[1]) m_val = (m_val + BCD_MOD - inc) % BCD_MOD;
            m_chg = stp[0] | stp[1];
            if (rise_o[2]) m_step10 = !m_step10;
            for (int b = 0; b < 3; b++) begin
                m_rise[b] = 0;
                if (m_s2[b] != m_db[b]) begin
                    m_cnt[b]++;
                    if (m_cnt[b] == DB) begin
                        m_db[b] = m_s2[b];
                        m_cnt[b] = 0;
                        m_rise[b] = m_db[b];
                    end
                end else begin
                    m_cnt[b] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = bus.BTN;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge INCLK) begin
        chk("tens",   int'(bus.BCD_TENS), m_val / 10);
        chk("ones",   int'(bus.BCD_ONES), m_val % 10);
        chk("value",  int'(bus.VALUE),    m_val);
        chk("step10", int'(bus.STEP10),   int'(m_step10));
        chk("chg",    int'(bus.CHG),      int'(m_chg));
        chk("btn_db", int'(bus.BTN_DB),   int'(m_db));
        if (bus.CHG) chg_total++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge INCLK);
    endtask

    task automatic do_reset();
        #2 RST = 1'b0;
        #1;
        chk("rst_tens",   int'(bus.BCD_TENS), 0);
        chk("rst_ones",   int'(bus.BCD_ONES), 0);
        chk("rst_value",  int'(bus.VALUE),    0);
        chk("rst_step10", int'(bus.STEP10),   0);
        chk("rst_chg",    int'(bus.CHG),      0);
        chk("rst_btn_db", int'(bus.BTN_DB),   0);
        cyc(2);
        RST = 1'b1;
        cyc(1);
    endtask

    task automatic press(input int b);
        bus.BTN[b] = 1'b1;
        cyc(8);
        bus.BTN[b] = 1'b0;
        cyc(10);
    endtask

    int c0;

    initial begin
        RST = 1'b0;
        bus.BTN = 3'b000;
        cyc(3);
        RST = 1'b1;

        // 1. idle after reset, then reset mid-press
        c0 = chg_total;
        cyc(50);
        chk("idle_value", int'(bus.VALUE), 0);
        chk("idle_chg_count", chg_total - c0, 0);
        bus.BTN[BTN_UP] = 1'b1;
        cyc(10);
        chk("pre_rst_value", int'(bus.VALUE), 1);
        do_reset();
        cyc(10);
        chk("held_after_rst", int'(bus.VALUE), 1);
        bus.BTN[BTN_UP] = 1'b0;
        cyc(10);
        do_reset();

        // 2. glitches alone, then bounce into a stable hold
        c0 = chg_total;
        for (int g = 1; g <= 3; g++) begin
            bus.BTN[BTN_UP] = 1'b1; cyc(g);
            bus.BTN[BTN_UP] = 1'b0; cyc(2);
        end
        cyc(6);
        chk("glitch_chg_count", chg_total - c0, 0);
        chk("glitch_btn_db", int'(bus.BTN_DB), 0);
        bus.BTN[BTN_UP] = 1'b1; cyc(1);
        bus.BTN[BTN_UP] = 1'b0; cyc(1);
        bus.BTN[BTN_UP] = 1'b1;
        cyc(6);
        chk("latency_before", int'(bus.VALUE), 0);
        cyc(1);
        chk("latency_value", int'(bus.VALUE), 1);
        chk("latency_chg", int'(bus.CHG), 1);
        cyc(1);
        bus.BTN[BTN_UP] = 1'b0;
        cyc(10);
        chk("bounce_chg_count", chg_total - c0, 1);

        // 3. auto-repeat from 00
        do_reset();
        c0 = chg_total;
        bus.BTN[BTN_UP] = 1'b1;
        cyc(38);
        bus.BTN[BTN_UP] = 1'b0;
        cyc(60);
        chk("repeat_value", int'(bus.VALUE), 5);
        chk("repeat_chg_count", chg_total - c0, 5);

        // 4. wrap, step 1
        do_reset();
        press(BTN_DN); chk("dn_00_99", int'(bus.VALUE), 99);
        press(BTN_UP); chk("up_99_00", int'(bus.VALUE), 0);
        press(BTN_DN); chk("dn_00_99b", int'(bus.VALUE), 99);
        press(BTN_DN); chk("dn_99_98", int'(bus.VALUE), 98);
        do_reset();
        for (int k = 0; k < 9; k++) press(BTN_UP);
        chk("up_to_09", int'(bus.VALUE), 9);
        press(BTN_UP); chk("up_09_10", int'(bus.BCD_TENS) * 16 + int'(bus.BCD_ONES), 'h10);
        press(BTN_DN); chk("dn_10_09", int'(bus.VALUE), 9);

        // 5. wrap, step 10
        do_reset();
        for (int k = 0; k < 5; k++) press(BTN_DN);
        chk("set_95", int'(bus.VALUE), 95);
        c0 = chg_total;
        press(BTN_MODE);
        chk("mode_step10", int'(bus.STEP10), 1);
        chk("mode_no_chg", chg_total - c0, 0);
        press(BTN_UP); chk("up10_95_05", int'(bus.VALUE), 5);
        press(BTN_DN); chk("dn10_05_95", int'(bus.VALUE), 95);
        press(BTN_DN); chk("dn10_95_85", int'(bus.VALUE), 85);
        do_reset();
        for (int k = 0; k < 3; k++) press(BTN_UP);
        press(BTN_MODE);
        press(BTN_DN); chk("dn10_03_93", int'(bus.VALUE), 93);
        bus.BTN = 3'b101;
        cyc(8);
        bus.BTN = 3'b000;
        cyc(10);
        chk("same_cycle_value", int'(bus.VALUE), 3);
        chk("same_cycle_step10", int'(bus.STEP10), 0);

        // 6. up and down held together
        do_reset();
        c0 = chg_total;
        bus.BTN = 3'b011;
        cyc(100);
        chk("both_chg_count", chg_total - c0, 0);
        bus.BTN = 3'b001;
        cyc(60);
        chk("one_released_chg", chg_total - c0, 0);
        chk("one_released_val", int'(bus.VALUE), 0);
        bus.BTN = 3'b000;
        cyc(10);
        press(BTN_UP);
        chk("repress_value", int'(bus.VALUE), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
